// File: rtl/conv_stream_pkg.sv
// Shared types and helpers for the streaming convolution engine.
// Imported by the line buffer and the engine top.
package conv_stream_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_WGT,
      S_STREAM,
      S_COMMIT,
      S_OUTPUT
   } state_t;

   function automatic int ofm_size(input int n, input int k, input int s);
      return (n - k) / s + 1;
   endfunction

   // Full-precision width of a KxK sum of pixel*weight products.
   function automatic int mac_width(input int iw, input int ww, input int k);
      return iw + 1 + ww + $clog2(k * k);
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row delay lines plus the KxK sliding window register.
// Window element (r,c) is packed MSB-first in raster order.
module conv_line_buffer
   import conv_stream_pkg::*;
#(
   parameter int IW = 8,
   parameter int K  = 3,
   parameter int N  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic [IW-1:0]     din,
   output logic [K*K*IW-1:0] window
);

   logic [IW-1:0] lb  [K-1][N];
   logic [IW-1:0] win [K][K];
   logic [IW-1:0] tap [K];

   // tap[j] is the pixel j rows above the incoming one
   always_comb begin
      tap[0] = din;
      for (int j = 1; j < K; j++)
         tap[j] = lb[j-1][N-1];
   end

   always_ff @(posedge clk) begin
      if (shift_en) begin
         for (int j = 0; j < K - 1; j++) begin
            for (int i = N - 1; i > 0; i--)
               lb[j][i] <= lb[j][i-1];
            lb[j][0] <= tap[j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               win[r][c] <= '0;
      end else if (shift_en) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++)
               win[r][c] <= win[r][c+1];
            win[r][K-1] <= tap[K-1-r];
         end
      end
   end

   always_comb begin
      window = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            window[(K*K-1-(r*K+c))*IW +: IW] = win[r][c];
   end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution with channel accumulation, stride and ReLU.
// Finished output map is streamed from the psum array with backpressure.
module conv_stream_engine
   import conv_stream_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int IFM_WIDTH    = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int KERNEL_SIZE  = 3,
   parameter int IFM_SIZE     = 9,
   parameter int STRIDE       = 1,
   parameter int CI           = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic relu_en,
   input  logic wgt_valid,
   output logic wgt_ready,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] wgt,
   input  logic ifm_valid,
   output logic ifm_ready,
   input  logic [IFM_WIDTH-1:0] ifm,
   output logic out_valid,
   input  logic out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic out_last,
   output logic busy,
   output logic end_conv
);

   localparam int K   = KERNEL_SIZE;
   localparam int KK  = K * K;
   localparam int OFM = ofm_size(IFM_SIZE, K, STRIDE);
   localparam int NO  = OFM * OFM;
   localparam int RW  = $clog2(IFM_SIZE);
   localparam int XW  = $clog2(NO + 1);
   localparam int CW  = (CI > 1) ? $clog2(CI) : 1;

   state_t state, state_n;
   logic [RW-1:0] row, col;
   logic [CW-1:0] ch;
   logic relu_q;
   logic [KK*WEIGHT_WIDTH-1:0] wgt_q;
   logic [KK*IFM_WIDTH-1:0] window;
   logic mac_vld;
   logic [XW-1:0] mac_idx, oidx, win_idx;
   logic [DATA_WIDTH-1:0] psum [NO];
   logic [DATA_WIDTH-1:0] mac_sum, rd;
   logic win_ok, wgt_hs, ifm_hs, out_hs, last_px;

   assign wgt_hs  = wgt_valid && wgt_ready;
   assign ifm_hs  = ifm_valid && ifm_ready;
   assign out_hs  = out_valid && out_ready;
   assign last_px = ifm_hs && row == RW'(IFM_SIZE - 1)
                           && col == RW'(IFM_SIZE - 1);
   assign rd      = psum[oidx];

   conv_line_buffer #(
      .IW(IFM_WIDTH), .K(K), .N(IFM_SIZE)
   ) u_lb (
      .clk(clk), .rst_n(rst_n), .shift_en(ifm_hs),
      .din(ifm), .window(window)
   );

   always_comb begin
      state_n   = state;
      wgt_ready = 1'b0;
      ifm_ready = 1'b0;
      busy      = (state != S_IDLE);
      unique case (state)
         S_IDLE:     if (start) state_n = S_LOAD_WGT;
         S_LOAD_WGT: begin
            wgt_ready = 1'b1;
            if (wgt_valid) state_n = S_STREAM;
         end
         S_STREAM:   begin
            ifm_ready = 1'b1;
            if (last_px) state_n = S_COMMIT;
         end
         S_COMMIT:
            state_n = (ch == CW'(CI - 1)) ? S_OUTPUT : S_LOAD_WGT;
         S_OUTPUT:   if (out_hs && out_last) state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
   end

   // Window position relative to the first full window, in stride steps
   always_comb begin : win_calc
      int rr;
      int cc;
      rr = int'(row) - (K - 1);
      cc = int'(col) - (K - 1);
      win_ok = rr >= 0 && cc >= 0
            && (rr % STRIDE) == 0 && (cc % STRIDE) == 0
            && (rr / STRIDE) < OFM && (cc / STRIDE) < OFM;
      win_idx = win_ok ? XW'((rr / STRIDE) * OFM + cc / STRIDE) : '0;
   end

   // Modular arithmetic makes DATA_WIDTH-wide products exact after truncation
   always_comb begin : mac
      logic [DATA_WIDTH-1:0] a, b;
      mac_sum = '0;
      for (int e = 0; e < KK; e++) begin
         a = DATA_WIDTH'(window[(KK-1-e)*IFM_WIDTH +: IFM_WIDTH]);
         b = DATA_WIDTH'(signed'(wgt_q[(KK-1-e)*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
         mac_sum = mac_sum + a * b;
      end
   end

   always_ff @(posedge clk) begin
      if (mac_vld)
         psum[mac_idx] <= (ch == '0) ? mac_sum : psum[mac_idx] + mac_sum;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         row       <= '0;
         col       <= '0;
         ch        <= '0;
         relu_q    <= 1'b0;
         wgt_q     <= '0;
         mac_vld   <= 1'b0;
         mac_idx   <= '0;
         oidx      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         end_conv  <= 1'b0;
      end else begin
         state    <= state_n;
         mac_vld  <= ifm_hs && win_ok;
         mac_idx  <= win_idx;
         end_conv <= (state == S_OUTPUT) && out_hs && out_last;
         unique case (state)
            S_IDLE: if (start) begin
               ch     <= '0;
               relu_q <= relu_en;
            end
            S_LOAD_WGT: if (wgt_hs) begin
               wgt_q <= wgt;
               row   <= '0;
               col   <= '0;
            end
            S_STREAM: if (ifm_hs) begin
               if (col == RW'(IFM_SIZE - 1)) begin
                  col <= '0;
                  row <= (row == RW'(IFM_SIZE - 1)) ? '0 : row + RW'(1);
               end else begin
                  col <= col + RW'(1);
               end
            end
            S_COMMIT: begin
               oidx <= '0;
               if (ch != CW'(CI - 1)) ch <= ch + CW'(1);
            end
            S_OUTPUT: begin
               if (out_hs && out_last) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else if (!out_valid || out_ready) begin
                  out_valid <= 1'b1;
                  out_data  <= (relu_q && rd[DATA_WIDTH-1]) ? '0 : rd;
                  out_last  <= (oidx == XW'(NO - 1));
                  oidx      <= oidx + XW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench: u_a is N=5,S=1,CI=1; u_c is N=7,S=2,CI=2.
// Stimulus pushes expected pixels; the monitor pops and compares.
module tb_conv_stream_engine;

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, sel, start, relu_en, wgt_valid, ifm_valid, out_ready;
   logic [71:0] wgt;
   logic [7:0]  ifm;
   logic start_a, start_c;
   logic wr_a, ir_a, ov_a, ol_a, bz_a, ec_a;
   logic wr_c, ir_c, ov_c, ol_c, bz_c, ec_c;
   logic [15:0] od_a, od_c;
   logic wgt_ready, ifm_ready, out_valid, out_last, busy, end_conv;
   logic [15:0] out_data;

   assign start_a   = start && !sel;
   assign start_c   = start && sel;
   assign wgt_ready = sel ? wr_c : wr_a;
   assign ifm_ready = sel ? ir_c : ir_a;
   assign out_valid = sel ? ov_c : ov_a;
   assign out_data  = sel ? od_c : od_a;
   assign out_last  = sel ? ol_c : ol_a;
   assign busy      = sel ? bz_c : bz_a;
   assign end_conv  = sel ? ec_c : ec_a;

   conv_stream_engine #(
      .DATA_WIDTH(16), .IFM_WIDTH(8), .WEIGHT_WIDTH(8),
      .KERNEL_SIZE(3), .IFM_SIZE(5), .STRIDE(1), .CI(1)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .relu_en(relu_en),
      .wgt_valid(wgt_valid), .wgt_ready(wr_a), .wgt(wgt),
      .ifm_valid(ifm_valid), .ifm_ready(ir_a), .ifm(ifm),
      .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
      .out_last(ol_a), .busy(bz_a), .end_conv(ec_a)
   );

   conv_stream_engine #(
      .DATA_WIDTH(16), .IFM_WIDTH(8), .WEIGHT_WIDTH(8),
      .KERNEL_SIZE(3), .IFM_SIZE(7), .STRIDE(2), .CI(2)
   ) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .relu_en(relu_en),
      .wgt_valid(wgt_valid), .wgt_ready(wr_c), .wgt(wgt),
      .ifm_valid(ifm_valid), .ifm_ready(ir_c), .ifm(ifm),
      .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
      .out_last(ol_c), .busy(bz_c), .end_conv(ec_c)
   );

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   logic chk_rst = 1'b0;
   logic done = 1'b0;
   logic tog_en = 1'b0;

   logic        prev_stall = 1'b0;
   logic [15:0] prev_data;
   logic        prev_last;
   logic        pend_end = 1'b0;
   int          nout = 0;

   always @(negedge clk) begin
      exp_t e;
      if (chk_rst) begin
         tests++;
         if ({wgt_ready, ifm_ready, out_valid, out_data,
              out_last, busy, end_conv} !== 22'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%b want=0",
               {wgt_ready, ifm_ready, out_valid, out_data,
                out_last, busy, end_conv});
         end
      end
      if (pend_end) begin
         tests++;
         if (end_conv !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL end_conv got end_conv=%b busy=%b want 1/0",
               end_conv, busy);
         end
         pend_end = 1'b0;
      end
      if (prev_stall) begin
         tests++;
         if (out_data !== prev_data || out_last !== prev_last) begin
            fails++;
            $display("FAIL stall_hold got=%h/%b want=%h/%b",
               out_data, out_last, prev_data, prev_last);
         end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         tests++;
         nout++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out #%0d got=%h", nout, out_data);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e.d || out_last !== e.l) begin
               fails++;
               $display("FAIL out #%0d got=%h last=%b want=%h last=%b",
                  nout, out_data, out_last, e.d, e.l);
            end
         end
         if (out_last === 1'b1) pend_end = 1'b1;
      end
      prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
         tests++;
         if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
         end
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = tog_en ? ~out_ready : 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      exp_q.push_back(e);
   endtask

   function automatic logic [71:0] wfill(input logic [7:0] v,
                                         input logic [7:0] ctr);
      logic [71:0] w;
      for (int e = 0; e < 9; e++)
         w[(8-e)*8 +: 8] = (e == 4) ? ctr : v;
      return w;
   endfunction

   task automatic start_map(input logic r);
      relu_en = r;
      start = 1'b1;
      tick();
      start = 1'b0;
      relu_en = 1'b0;
   endtask

   task automatic do_chan(input logic [71:0] w, input int n,
                          input int pmode, input int pval,
                          input bit rnd, input int npix);
      int k;
      k = 0;
      wgt = w;
      wgt_valid = 1'b1;
      while (!wgt_ready) tick();
      tick();
      wgt_valid = 1'b0;
      for (int r = 0; r < n; r++) begin
         for (int c = 0; c < n; c++) begin
            if (k < npix) begin
               if (rnd) repeat ($urandom_range(1, 0)) tick();
               ifm = (pmode == 1) ? 8'(r * n + c) : 8'(pval);
               ifm_valid = 1'b1;
               while (!ifm_ready) tick();
               tick();
               ifm_valid = 1'b0;
               k++;
            end
         end
      end
   endtask

   task automatic drain;
      for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++)
         tick();
      repeat (3) tick();
   endtask

   task automatic push_const(input logic [15:0] v);
      for (int i = 0; i < 9; i++) push(v, i == 8);
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; start = 1'b0; relu_en = 1'b0;
      wgt_valid = 1'b0; ifm_valid = 1'b0; wgt = '0; ifm = '0;
      repeat (2) tick();
      chk_rst = 1'b1;
      @(negedge clk); #1;
      chk_rst = 1'b0;
      rst_n = 1'b1;
      tick();

      // all ones, 3x3 of 1s
      sel = 1'b0;
      push_const(16'd9);
      start_map(1'b0);
      do_chan(wfill(8'd1, 8'd1), 5, 0, 1, 0, 25);
      drain();

      // two channels on u_c: 18 - 9
      sel = 1'b1;
      push_const(16'd9);
      start_map(1'b0);
      do_chan(wfill(8'd1, 8'd1), 7, 0, 2, 0, 49);
      do_chan(wfill(8'hFF, 8'hFF), 7, 0, 1, 0, 49);
      drain();

      // negative sums, relu off then on
      sel = 1'b0;
      push_const(16'hFFF7);
      start_map(1'b0);
      do_chan(wfill(8'hFF, 8'hFF), 5, 0, 1, 0, 25);
      drain();
      push_const(16'h0000);
      start_map(1'b1);
      do_chan(wfill(8'hFF, 8'hFF), 5, 0, 1, 0, 25);
      drain();

      // stride 2, centre tap, second channel adds zero
      sel = 1'b1;
      for (int oy = 0; oy < 3; oy++)
         for (int ox = 0; ox < 3; ox++)
            push(16'(14 * oy + 2 * ox + 8), oy == 2 && ox == 2);
      start_map(1'b0);
      do_chan(wfill(8'd0, 8'd1), 7, 1, 0, 0, 49);
      do_chan(wfill(8'd0, 8'd0), 7, 0, 1, 0, 49);
      drain();

      // ramp image with ifm gaps and output backpressure
      sel = 1'b0;
      for (int oy = 0; oy < 3; oy++)
         for (int ox = 0; ox < 3; ox++)
            push(16'(9 * (5 * oy + ox + 6)), oy == 2 && ox == 2);
      tog_en = 1'b1;
      start_map(1'b0);
      do_chan(wfill(8'd1, 8'd1), 5, 1, 0, 1, 25);
      drain();
      tog_en = 1'b0;
      tick();

      // reset mid-stream, then a clean map
      sel = 1'b0;
      start_map(1'b0);
      do_chan(wfill(8'd3, 8'd3), 5, 0, 7, 0, 7);
      rst_n = 1'b0;
      tick();
      chk_rst = 1'b1;
      @(negedge clk); #1;
      chk_rst = 1'b0;
      rst_n = 1'b1;
      tick();
      push_const(16'd9);
      start_map(1'b0);
      do_chan(wfill(8'd1, 8'd1), 5, 0, 1, 0, 25);
      drain();

      done = 1'b1;
   end

endmodule
